// File: rtl/async_event_pkg.sv
// Shared types and constants for the asynchronous event synchronizer.
// Edge qualification is centralised here so every channel decodes mode identically.
package async_event_pkg;

   typedef enum logic [1:0] {
      EVT_OFF  = 2'b00,
      EVT_RISE = 2'b01,
      EVT_FALL = 2'b10,
      EVT_BOTH = 2'b11
   } evt_mode_t;

   localparam int MIN_SYNC_STAGES = 2;

   // True when a level transition in the given direction should be reported.
   function automatic logic edge_match(input evt_mode_t m, input logic rising);
      return (m == EVT_BOTH) ||
             ((m == EVT_RISE) && rising) ||
             ((m == EVT_FALL) && !rising);
   endfunction

endpackage

// File: rtl/async_event_channel.sv
// One event channel: synchronizer chain, glitch filter, edge-qualified pulse,
// sticky flag and saturating counter.
module async_event_channel
   import async_event_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 async_in,
   input  evt_mode_t            mode,
   input  logic                 clear_flags,
   input  logic                 clear_count,
   output logic                 sync_level,
   output logic                 event_pulse,
   output logic                 event_flag,
   output logic [CNT_WIDTH-1:0] event_count
);

   localparam int                   FCNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(FILTER_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [FCNT_W-1:0]      fcnt;
   logic                   s;
   logic                   toggle;

   assign s      = sync_q[SYNC_STAGES-1];
   assign toggle = (s != sync_level) && (fcnt == FCNT_LAST);

   // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q      <= '0;
         fcnt        <= '0;
         sync_level  <= 1'b0;
         event_pulse <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], async_in};
         event_pulse <= toggle && edge_match(mode, !sync_level);
         if (s == sync_level) begin
            fcnt <= '0;
         end else if (toggle) begin
            sync_level <= ~sync_level;
            fcnt       <= '0;
         end else begin
            fcnt <= fcnt + FCNT_W'(1);
         end
      end
   end

   // Flag: a pulse beats a clear. Counter: a clear beats a pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         event_flag  <= 1'b0;
         event_count <= '0;
      end else begin
         if (event_pulse)
            event_flag <= 1'b1;
         else if (clear_flags)
            event_flag <= 1'b0;

         if (clear_count)
            event_count <= '0;
         else if (event_pulse && (event_count != CNT_MAX))
            event_count <= event_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/async_event_sync.sv
// Multi-channel asynchronous event synchronizer; all outputs are in the clk domain.
// Channels are fully independent instances of async_event_channel.
module async_event_sync
   import async_event_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           async_in,
   input  logic [2*NUM_CH-1:0]         mode,
   input  logic                        clear_flags,
   input  logic                        clear_count,
   output logic [NUM_CH-1:0]           sync_level,
   output logic [NUM_CH-1:0]           event_pulse,
   output logic [NUM_CH-1:0]           event_flag,
   output logic [NUM_CH*CNT_WIDTH-1:0] event_count
);

   if (NUM_CH < 1) begin : g_bad_num_ch
      $error("async_event_sync: NUM_CH must be >= 1");
   end
   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync_stages
      $error("async_event_sync: SYNC_STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
      $error("async_event_sync: FILTER_CYCLES must be >= 1");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("async_event_sync: CNT_WIDTH must be >= 1");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      async_event_channel #(
         .SYNC_STAGES  (SYNC_STAGES),
         .FILTER_CYCLES(FILTER_CYCLES),
         .CNT_WIDTH    (CNT_WIDTH)
      ) u_ch (
         .clk        (clk),
         .reset      (reset),
         .async_in   (async_in[i]),
         .mode       (evt_mode_t'(mode[2*i +: 2])),
         .clear_flags(clear_flags),
         .clear_count(clear_count),
         .sync_level (sync_level[i]),
         .event_pulse(event_pulse[i]),
         .event_flag (event_flag[i]),
         .event_count(event_count[CNT_WIDTH*i +: CNT_WIDTH])
      );
   end

endmodule
